// File: rtl/nclic_pkg.sv
// ----------------------------------------------------------------------------
// nclic_pkg
// Shared configuration and types for the nested interrupt dispatcher.
//   INT_AMOUNT : number of interrupt sources
//   PRIORITIES : number of priority levels (level 0 is never taken)
//   IntId      : source index type
//   IntPrio    : priority type, also used for the nesting stack pointer
//   state_e    : dispatcher FSM state
// ----------------------------------------------------------------------------
package nclic_pkg;

   localparam int INT_AMOUNT = 8;
   localparam int PRIORITIES = 4;

   typedef logic [$clog2(INT_AMOUNT)-1:0] IntId;
   typedef logic [$clog2(PRIORITIES)-1:0] IntPrio;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

endpackage

// File: rtl/nclic_dispatch_tree.sv
// ----------------------------------------------------------------------------
// nclic_dispatch_tree
// Combinational max-finder over N values, built as a binary tree.
// Ties resolve to the lower index, since the left child of every node holds
// the lower-numbered leaves.
// Ports:
//   vals    : candidate values, one per index
//   win_val : largest value
//   win_idx : index of the largest value (lowest index on a tie)
// ----------------------------------------------------------------------------
module nclic_dispatch_tree #(
   parameter int  N       = 8,
   parameter type TreeVal = logic [1:0],
   parameter type TreeIdx = logic [2:0]
) (
   input  TreeVal vals [N],
   output TreeVal win_val,
   output TreeIdx win_idx
);

   // Leaves padded to a power of two; padding leaves carry value 0 and can
   // never beat a real leaf because the comparison is strict.
   localparam int LEAVES = 1 << $clog2(N);

   // Heap layout: node k has children 2k and 2k+1, leaves at LEAVES+i.
   TreeVal node_val [2*LEAVES];
   TreeIdx node_idx [2*LEAVES];

   always_comb begin
      // NOTE: every node gets a default before the reduction, so no path
      // leaves a variable unassigned and no latch is inferred.
      for (int k = 0; k < 2*LEAVES; k++) begin
         node_val[k] = '0;
         node_idx[k] = '0;
      end
      for (int i = 0; i < N; i++) begin
         node_val[LEAVES+i] = vals[i];
         node_idx[LEAVES+i] = TreeIdx'(i);
      end
      for (int k = LEAVES-1; k >= 1; k--) begin
         if (node_val[2*k+1] > node_val[2*k]) begin
            node_val[k] = node_val[2*k+1];
            node_idx[k] = node_idx[2*k+1];
         end else begin
            node_val[k] = node_val[2*k];
            node_idx[k] = node_idx[2*k];
         end
      end
      win_val = node_val[1];
      win_idx = node_idx[1];
   end

endmodule

// File: rtl/nclic_dispatch.sv
// ----------------------------------------------------------------------------
// nclic_dispatch
// Edge-triggered interrupt dispatcher with per-source priority/enable and a
// nesting stack of active handler priorities.
// Build option: NCLIC_PREEMPT_EN
//   defined   : nested preemption; a source is requested only when its
//               priority beats the priority on top of the nesting stack
//   undefined : single active slot; nothing is requested while a handler runs
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   irq               : interrupt sources, rising-edge sensitive
//   cfg_we/id/prio/en : write priority and enable of one source
//   req, req_id       : registered request to the core and its source id
//   ack               : core accepts the request (only while req is high)
//   done              : core finished the innermost active handler
// ----------------------------------------------------------------------------
module nclic_dispatch
   import nclic_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INT_AMOUNT-1:0] irq,
   input  logic                  cfg_we,
   input  IntId                  cfg_id,
   input  IntPrio                cfg_prio,
   input  logic                  cfg_en,
   output logic                  req,
   output IntId                  req_id,
   input  logic                  ack,
   input  logic                  done
);

   logic [INT_AMOUNT-1:0] irq_s;
   logic [INT_AMOUNT-1:0] irq_hist;
   logic [INT_AMOUNT-1:0] irq_edge;
   logic [INT_AMOUNT-1:0] pending;
   logic [INT_AMOUNT-1:0] pending_nxt;
   logic [INT_AMOUNT-1:0] enable;
   IntPrio                prio     [INT_AMOUNT];
   IntPrio                eff_prio [INT_AMOUNT];
   IntPrio                win_prio;
   IntId                  win_id;
   state_e                state;
   logic                  ack_fire;
   logic                  take;

   // irq is sampled once, then compared with the previous sample; this gives
   // the two-cycle latency from the sampled edge to req.
   assign irq_edge = irq_s & ~irq_hist;
   assign ack_fire = (state == REQ) && ack;

   always_comb begin
      for (int i = 0; i < INT_AMOUNT; i++) begin
         eff_prio[i] = (pending[i] && enable[i]) ? prio[i] : '0;
      end
   end

   nclic_dispatch_tree #(
      .N       (INT_AMOUNT),
      .TreeVal (IntPrio),
      .TreeIdx (IntId)
   ) u_tree (
      .vals    (eff_prio),
      .win_val (win_prio),
      .win_idx (win_id)
   );

   // Clear on accept first, then OR in new edges so a fresh edge on the
   // accepted source in the same cycle survives.
   always_comb begin
      pending_nxt = pending;
      if (ack_fire) begin
         pending_nxt[req_id] = 1'b0;
      end
      pending_nxt = pending_nxt | irq_edge;
   end

   // Source state: edge history, pending bits and configuration.
   always_ff @(posedge clk) begin
      // NOTE: state is written with <= so every flop takes its pre-edge
      // inputs no matter how the statements are ordered.
      if (reset) begin
         irq_s    <= '0;
         irq_hist <= '0;
         pending  <= '0;
         enable   <= '0;
         for (int i = 0; i < INT_AMOUNT; i++) begin
            prio[i] <= '0;
         end
      end else begin
         irq_s    <= irq;
         irq_hist <= irq_s;
         pending  <= pending_nxt;
         if (cfg_we) begin
            prio[cfg_id]   <= cfg_prio;
            enable[cfg_id] <= cfg_en;
         end
      end
   end

`ifdef NCLIC_PREEMPT_EN
   localparam int DEPTH = PRIORITIES - 1;

   IntPrio stack [DEPTH];
   IntPrio sp;
   IntPrio sp_dec;
   IntPrio threshold;
   IntPrio req_prio;
   logic   pop;

   assign sp_dec    = sp - IntPrio'(1);
   assign pop       = done && (sp != '0);
   assign threshold = (sp == '0) ? '0 : stack[sp_dec];
   assign take      = win_prio > threshold;

   // Simultaneous pop and push replace the top entry; depth is unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp <= '0;
      end else if (ack_fire && !pop) begin
         sp <= sp + IntPrio'(1);
      end else if (!ack_fire && pop) begin
         sp <= sp_dec;
      end
   end

   // NOTE: stack entries at or above sp are never read, so only the pointer
   // is reset and the storage stays a plain register file.
   always_ff @(posedge clk) begin
      if (ack_fire) begin
         stack[pop ? sp_dec : sp] <= req_prio;
      end
   end

   // Pushed priorities strictly increase, so a push onto a full stack
   // means the threshold logic is broken.
   assert property (@(posedge clk) disable iff (reset)
      !(ack_fire && !pop && (sp == IntPrio'(DEPTH))));
`else
   logic active;

   assign take = !active && (win_prio != '0);

   // Accept wins over done so an ack+done pair hands the slot straight on.
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
      end else if (ack_fire) begin
         active <= 1'b1;
      end else if (done) begin
         active <= 1'b0;
      end
   end
`endif

   // Request FSM; req_id is latched on entry to REQ and held until ack, so
   // later edges or configuration writes cannot change a posted request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         req    <= 1'b0;
         req_id <= '0;
`ifdef NCLIC_PREEMPT_EN
         req_prio <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state  <= REQ;
                  req    <= 1'b1;
                  req_id <= win_id;
`ifdef NCLIC_PREEMPT_EN
                  req_prio <= win_prio;
`endif
               end
            end
            REQ: begin
               if (ack) begin
                  state <= IDLE;
                  req   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nclic_dispatch.sv
// ----------------------------------------------------------------------------
// tb_nclic_dispatch
// Cycle table for nclic_dispatch: each row holds the inputs for one clock and
// the req/req_id expected after that clock. Expectations go into a scoreboard
// queue when a row is driven and are popped after the edge.
// Rows that depend on the nesting mode are selected with NCLIC_PREEMPT_EN.
// ----------------------------------------------------------------------------
module tb_nclic_dispatch;
   import nclic_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [INT_AMOUNT-1:0] irq;
   logic                  cfg_we;
   IntId                  cfg_id;
   IntPrio                cfg_prio;
   logic                  cfg_en;
   logic                  req;
   IntId                  req_id;
   logic                  ack;
   logic                  done;

   always #5 clk = ~clk;

   nclic_dispatch dut (
      .clk      (clk),
      .reset    (reset),
      .irq      (irq),
      .cfg_we   (cfg_we),
      .cfg_id   (cfg_id),
      .cfg_prio (cfg_prio),
      .cfg_en   (cfg_en),
      .req      (req),
      .req_id   (req_id),
      .ack      (ack),
      .done     (done)
   );

   typedef struct {
      logic                  rst;
      logic                  cfg_we;
      IntId                  cfg_id;
      IntPrio                cfg_prio;
      logic                  cfg_en;
      logic [INT_AMOUNT-1:0] irq;
      logic                  ack;
      logic                  done;
      logic                  exp_req;
      IntId                  exp_id;
   } vec_t;

   typedef struct {
      int   row;
      logic rst;
      logic req;
      IntId id;
   } exp_t;

   vec_t vecs [$];
   exp_t sb   [$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(logic [INT_AMOUNT-1:0] irq_v, logic ack_v,
                               logic done_v, logic er, int eid);
      vec_t v;
      v.rst      = 1'b0;
      v.cfg_we   = 1'b0;
      v.cfg_id   = '0;
      v.cfg_prio = '0;
      v.cfg_en   = 1'b0;
      v.irq      = irq_v;
      v.ack      = ack_v;
      v.done     = done_v;
      v.exp_req  = er;
      v.exp_id   = IntId'(eid);
      vecs.push_back(v);
   endfunction

   function automatic void add_cfg(int id, int p, logic en,
                                   logic [INT_AMOUNT-1:0] irq_v, logic er, int eid);
      vec_t v;
      v.rst      = 1'b0;
      v.cfg_we   = 1'b1;
      v.cfg_id   = IntId'(id);
      v.cfg_prio = IntPrio'(p);
      v.cfg_en   = en;
      v.irq      = irq_v;
      v.ack      = 1'b0;
      v.done     = 1'b0;
      v.exp_req  = er;
      v.exp_id   = IntId'(eid);
      vecs.push_back(v);
   endfunction

   function automatic void add_rst(logic [INT_AMOUNT-1:0] irq_v);
      vec_t v;
      v.rst      = 1'b1;
      v.cfg_we   = 1'b0;
      v.cfg_id   = '0;
      v.cfg_prio = '0;
      v.cfg_en   = 1'b0;
      v.irq      = irq_v;
      v.ack      = 1'b0;
      v.done     = 1'b0;
      v.exp_req  = 1'b0;
      v.exp_id   = '0;
      vecs.push_back(v);
   endfunction

   task automatic check(input string what, input int row,
                        input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL row%0d %s: got %0d expected %0d", row, what, got, want);
      end
   endtask

   initial begin
      exp_t e;

      reset    = 1'b1;
      irq      = '0;
      cfg_we   = 1'b0;
      cfg_id   = '0;
      cfg_prio = '0;
      cfg_en   = 1'b0;
      ack      = 1'b0;
      done     = 1'b0;

      // Reset state.
      add_rst('0);
      add_rst('0);

      // Common configuration: id2=3, id4=2, id5=1.
      add_cfg(2, 3, 1'b1, 8'h00, 1'b0, 0);
      add_cfg(4, 2, 1'b1, 8'h00, 1'b0, 0);
      add_cfg(5, 1, 1'b1, 8'h00, 1'b0, 0);

      // Edges on 2, 4, 5 together: req_id=2 two cycles after sampling.
      add(8'h34, 1'b0, 1'b0, 1'b0, 0);
      add(8'h34, 1'b0, 1'b0, 1'b0, 0);
      add(8'h34, 1'b0, 1'b0, 1'b1, 2);
      add(8'h00, 1'b1, 1'b0, 1'b0, 0);
      // Handler of prio 3 active: nothing else may be requested.
      add(8'h00, 1'b0, 1'b0, 1'b0, 0);
      add(8'h00, 1'b0, 1'b0, 1'b0, 0);
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(8'h00, 1'b0, 1'b0, 1'b1, 4);
      // Edge on 5 while req_id=4 awaits ack: request stays on 4.
      add(8'h20, 1'b0, 1'b0, 1'b1, 4);
      add(8'h20, 1'b0, 1'b0, 1'b1, 4);
      add(8'h20, 1'b1, 1'b0, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b0, 0);
      add(8'h20, 1'b0, 1'b1, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b1, 5);
      add(8'h20, 1'b1, 1'b0, 1'b0, 0);

`ifdef NCLIC_PREEMPT_EN
      // Stack [1]: edge on 4 preempts, then 2 preempts 4.
      add(8'h10, 1'b0, 1'b0, 1'b0, 0);
      add(8'h10, 1'b0, 1'b0, 1'b0, 0);
      add(8'h10, 1'b0, 1'b0, 1'b1, 4);
      add(8'h00, 1'b1, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b1, 2);
      add(8'h04, 1'b1, 1'b0, 1'b0, 0);
      // Three done pulses empty the stack: prio-1 source taken at once.
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b1, 5);
      // Stack [1], then ack+done on id4 leaves stack [2].
      add(8'h10, 1'b1, 1'b0, 1'b0, 0);
      add(8'h10, 1'b0, 1'b0, 1'b0, 0);
      add(8'h10, 1'b0, 1'b0, 1'b1, 4);
      add(8'h10, 1'b1, 1'b1, 1'b0, 0);
      // Prio-1 edge blocked by threshold 2 until one done.
      add(8'h20, 1'b0, 1'b0, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b0, 0);
      add(8'h20, 1'b0, 1'b1, 1'b0, 0);
      add(8'h20, 1'b0, 1'b0, 1'b1, 5);
      add(8'h00, 1'b1, 1'b0, 1'b0, 0);
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      // done on an empty stack must leave it empty.
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
`else
      // Slot busy: even the highest priority waits for done.
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add(8'h00, 1'b0, 1'b0, 1'b0, 0);
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b1, 2);
      // New edge on 2 in the ack cycle: pending survives.
      add(8'h04, 1'b1, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b1, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b1, 2);
      add(8'h04, 1'b1, 1'b0, 1'b0, 0);
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(8'h00, 1'b0, 1'b0, 1'b0, 0);
`endif

      // Disabled source keeps pending and is taken once re-enabled.
      add_cfg(2, 3, 1'b0, 8'h00, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b0, 0);
      add_cfg(2, 3, 1'b1, 8'h04, 1'b0, 0);
      add(8'h04, 1'b0, 1'b0, 1'b1, 2);
      add(8'h04, 1'b1, 1'b0, 1'b0, 0);
      add(8'h04, 1'b0, 1'b1, 1'b0, 0);
      // Reset while req=1, then pending must be gone after reconfiguring.
      add(8'h34, 1'b0, 1'b0, 1'b0, 0);
      add(8'h34, 1'b0, 1'b0, 1'b0, 0);
      add(8'h34, 1'b0, 1'b0, 1'b1, 4);
      add_rst(8'h00);
      add_cfg(4, 2, 1'b1, 8'h00, 1'b0, 0);
      add_cfg(5, 1, 1'b1, 8'h00, 1'b0, 0);
      add_cfg(2, 3, 1'b1, 8'h00, 1'b0, 0);
      add(8'h00, 1'b0, 1'b0, 1'b0, 0);
      // Equal priorities on 4 and 6: lower id first; cfg leaves latched req.
      add_cfg(6, 2, 1'b1, 8'h50, 1'b0, 0);
      add(8'h50, 1'b0, 1'b0, 1'b0, 0);
      add(8'h50, 1'b0, 1'b0, 1'b1, 4);
      add_cfg(4, 0, 1'b0, 8'h50, 1'b1, 4);
      add(8'h50, 1'b1, 1'b0, 1'b0, 0);
      add(8'h50, 1'b0, 1'b1, 1'b0, 0);
      add(8'h50, 1'b0, 1'b0, 1'b1, 6);
      add(8'h00, 1'b1, 1'b0, 1'b0, 0);
      add(8'h00, 1'b0, 1'b1, 1'b0, 0);
      add(8'h00, 1'b0, 1'b0, 1'b0, 0);

      @(negedge clk);
      foreach (vecs[i]) begin
         reset    = vecs[i].rst;
         cfg_we   = vecs[i].cfg_we;
         cfg_id   = vecs[i].cfg_id;
         cfg_prio = vecs[i].cfg_prio;
         cfg_en   = vecs[i].cfg_en;
         irq      = vecs[i].irq;
         ack      = vecs[i].ack;
         done     = vecs[i].done;
         e.row = i;
         e.rst = vecs[i].rst;
         e.req = vecs[i].exp_req;
         e.id  = vecs[i].exp_id;
         sb.push_back(e);
         @(posedge clk);
         @(negedge clk);
         e = sb.pop_front();
         check("req", e.row, 32'(req), 32'(e.req));
         if (e.req || e.rst) begin
            check("req_id", e.row, 32'(req_id), 32'(e.id));
         end
      end
      check("scoreboard_left", -1, 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nclic_dispatch.md
NCLIC_DISPATCH -- requirements
Module: nclic_dispatch

Interface
REQ-001 Parameter INT_AMOUNT, default 8: number of interrupt sources; IntId width is $clog2(INT_AMOUNT).
REQ-002 Parameter PRIORITIES, default 4: number of priority levels; IntPrio width is $clog2(PRIORITIES); level 0 means never taken.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq  in  INT_AMOUNT  interrupt sources, rising-edge sensitive.
REQ-006 cfg_we  in  1  configuration write strobe.
REQ-007 cfg_id  in  IntId  source selected by the configuration write.
REQ-008 cfg_prio  in  IntPrio  priority written to the selected source.
REQ-009 cfg_en  in  1  enable bit written to the selected source.
REQ-010 req  out  1  interrupt request to the core.
REQ-011 req_id  out  IntId  id of the requested source; stable while req is high.
REQ-012 ack  in  1  core accepts the request; valid only while req is high.
REQ-013 done  in  1  core completes the innermost active handler.

Function
REQ-014 A 0-to-1 transition of irq[i] between consecutive clk edges shall set pending[i] on the next edge.
REQ-015 Effective priority of source i shall be prio[i] if pending[i] and enable[i] are both set, else 0.
REQ-016 The winner shall be the source with the highest effective priority, with ties resolved to the lowest id.
REQ-017 Threshold shall be the priority on top of the nesting stack, or 0 when the stack is empty.
REQ-018 FSM states shall be IDLE and REQ; IDLE -> REQ when winner priority > threshold, latching winner id and priority.
REQ-019 In REQ, req=1 and req_id shall hold the latched id; no re-arbitration occurs until ack.
REQ-020 REQ -> IDLE on ack: push latched priority, clear pending[req_id].
REQ-021 An edge on irq[req_id] in the same cycle as ack shall leave pending set (set wins).
REQ-022 Latency shall be 2 cycles from the irq rising edge being sampled to req high.
REQ-023 done shall pop the stack; done with an empty stack shall be ignored.
REQ-024 ack and done in the same cycle shall pop, then push (top replaced).
REQ-025 Stack depth shall be PRIORITIES-1; pushes are strictly increasing, so overflow is impossible and is flagged by an assertion.
REQ-026 cfg_we shall update prio[cfg_id] and enable[cfg_id] on the next edge and shall not alter a request already latched.
REQ-027 Disabling a source shall keep its pending bit, so re-enabling it makes it eligible again.

Reset
REQ-028 Reset shall force req=0, req_id=0, FSM=IDLE, stack empty, and all pending, enable, prio and irq history bits to 0.
REQ-029 Reset asserted mid-request shall drop req on the next edge and discard all pending interrupts.

Configuration
REQ-030 Macro NCLIC_PREEMPT_EN defined: nesting per REQ-017..REQ-025.
REQ-031 Macro NCLIC_PREEMPT_EN undefined: a single active slot; while a handler is active no req is raised regardless of priority; done frees the slot.

Structure
REQ-032 Package nclic_pkg shall hold INT_AMOUNT, PRIORITIES, IntPrio, IntId and the FSM state enum.
REQ-033 The winner search shall use the existing tree sub-module (TreeVal=IntPrio, TreeIdx=IntId) instantiated once.

Verification
Common configuration for V1-V4 and V6: prio id2=3, id4=2, id5=1, all enabled.
REQ-034 V1: edges on irq 2, 4 and 5 in the same cycle -> req_id=2 two cycles later; ack; then no req until done.
REQ-035 V2 (preempt): ack id5 (threshold 1); edge irq4 -> req_id=4; ack; edge irq2 -> req_id=2; three done pulses -> stack empty.
REQ-036 V3: edge irq5 while req_id=4 is pending ack -> req_id stays 4 until ack, then 5 is requested only after done.
REQ-037 V4: ack and done in the same cycle with stack [1] -> stack [prio of acked source].
REQ-038 V5: cfg disable id2, edge irq2 -> no req; re-enable -> req_id=2 within 2 cycles.
REQ-039 V6: reset while req=1 -> next cycle req=0, req_id=0, all pending bits 0.
